// File: rtl/bg_mem_pkg.sv
// Shared types and constants for the background frame-memory arbiter.
package bg_mem_pkg;

    localparam int ADDR_W      = 17;     // 320x240 words
    localparam int DATA_W      = 12;     // RGB444
    localparam int FRAME_WORDS = 76800;

    // Aux port state: free to grant, or waiting for its single outstanding read
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } aux_state_e;

    // In-flight read tag: which requester owns the data coming back
    localparam int TAG_W    = 2;
    localparam int TAG_AUX  = 0;
    localparam int TAG_DISP = 1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: a tag entering now leaves RD_LAT cycles later, aligned
// with the memory's read data.
module rd_tag_pipe
    import bg_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
);

    logic [RD_LAT-1:0][TAG_W-1:0] vld_pipe_q;
    logic [RD_LAT-1:0][TAG_W-1:0] vld_pipe_d;

    // Shift by one stage per cycle; stage 0 takes this cycle's grant
    always_comb begin
        vld_pipe_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    // Stage registers; reset discards every in-flight tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_pipe_q <= '0;
        else      vld_pipe_q <= vld_pipe_d;
    end

    assign tag_out = vld_pipe_q[RD_LAT-1];

endmodule

// File: rtl/bg_mem_arbiter.sv
// Single-port background memory arbiter: display reads have absolute priority
// and fixed latency; the aux port uses the leftover cycles, one read in flight.
module bg_mem_arbiter
    import bg_mem_pkg::*;
#(
    parameter int ADDR_W       = bg_mem_pkg::ADDR_W,
    parameter int DATA_W       = bg_mem_pkg::DATA_W,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic              aux_starved,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

    aux_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
    logic [TAG_W-1:0]  tag_in, tag_out;
    logic              disp_go;

    // Grant decision; rst gates it so the memory stays quiet while held in reset
    always_comb begin
        disp_go = rst & disp_req;
        aux_gnt = rst & ~disp_req & aux_req & (state_q == IDLE);
    end

    // Memory port mux: display first, then a granted aux access, else idle zeros
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (disp_go) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (aux_gnt) begin
            mem_en   = 1'b1;
            mem_we   = aux_we;
            mem_addr = aux_addr;
            mem_din  = aux_wdata;
        end
    end

    // Tag this cycle's read so the returning word finds its owner
    always_comb begin
        tag_in           = '0;
        tag_in[TAG_DISP] = disp_go;
        tag_in[TAG_AUX]  = aux_gnt & ~aux_we;
    end

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign disp_valid = tag_out[TAG_DISP];
    assign aux_rvalid = tag_out[TAG_AUX];

    // Read data passes straight through on its valid cycle, then holds
    always_comb begin
        disp_data_d = disp_valid ? mem_dout : disp_data_q;
        aux_rdata_d = aux_rvalid ? mem_dout : aux_rdata_q;
    end

    assign disp_data = disp_data_d;
    assign aux_rdata = aux_rdata_d;

    // Aux FSM: a read grant blocks further grants until its data returns
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aux_gnt && !aux_we) state_d = RD_WAIT;
            RD_WAIT: if (aux_rvalid)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Starvation counter: counts denied request cycles, saturates, clears on grant
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (aux_gnt)                             starve_cnt_d = '0;
        else if (aux_req && starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    assign aux_starved = (starve_cnt_q == CNT_MAX);

    // State, counter and held read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            disp_data_q  <= '0;
            aux_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            disp_data_q  <= disp_data_d;
            aux_rdata_q  <= aux_rdata_d;
        end
    end

endmodule
